// File: rtl/int_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation per start, WIDTH iteration cycles, one-cycle done pulse.
module int_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_next;

  logic             rem_sel;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             is_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, FIN: state_next = start ? CALC : IDLE;
      CALC:      if (cnt == '0) state_next = FIN;
      default:   state_next = IDLE;
    endcase
  end

  assign busy   = (state == CALC);
  assign done   = (state == FIN);
  assign accept = start && (state != CALC);

  assign is_signed = ~op[0];
  assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

  // The partial remainder is always below the divisor, so a WIDTH+1-bit
  // difference's top bit is a reliable borrow even for divisors >= 2^(WIDTH-1).
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, divisor};
  assign rem_step = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};

  // Divide-by-zero and signed overflow fall out of the plain algorithm plus
  // these sign fixes, so no special-case datapath is needed.
  assign quo_fix = q_neg ? -quo_step : quo_step;
  assign rem_fix = r_neg ? -rem_step : rem_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_sel <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      rem_sel <= op[1];
      q_neg   <= is_signed && (a[WIDTH-1] != b[WIDTH-1]) && (b != '0);
      r_neg   <= is_signed && a[WIDTH-1];
      divisor <= abs_b;
      rem     <= '0;
      quo     <= abs_a;
      cnt     <= CW'(WIDTH - 1);
    end else if (state == CALC) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt - 1'b1;
      if (cnt == '0) result <= rem_sel ? rem_fix : quo_fix;
    end
  end

endmodule

// File: tb/tb_int_divider.sv
// Directed self-checking bench for int_divider (WIDTH=32): latency, results,
// special cases, start handshake and asynchronous reset.
module tb_int_divider;

  localparam int W = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int vectors = 0;
  int errors  = 0;

  int_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; returns #1 after the accepting edge N.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0003;
    op    = ~o;
  endtask

  // Full operation with timing checks. b2b=1 launches immediately (in the
  // previous FIN cycle); glitch=1 pulses start with other operands mid-CALC.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp,
                       input logic [W-1:0] prev, input bit b2b, input bit glitch);
    if (!b2b) @(negedge clk);
    applyStimulus(o, x, y);
    checkOutput({tag, " busy@N"}, {31'b0, busy}, 32'd1);
    checkOutput({tag, " done@N"}, {31'b0, done}, 32'd0);
    for (int i = 1; i < W; i++) begin
      @(posedge clk);
      #1;
      if (glitch && i == 9) begin
        op    = OP_REMU;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
      end
      if (glitch && i == 10) start = 1'b0;
    end
    checkOutput({tag, " busy@N+W-1"}, {31'b0, busy}, 32'd1);
    checkOutput({tag, " done@N+W-1"}, {31'b0, done}, 32'd0);
    checkOutput({tag, " held"}, result, prev);
    @(posedge clk);
    #1;
    checkOutput({tag, " done@N+W"}, {31'b0, done}, 32'd1);
    checkOutput({tag, " busy@N+W"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, " result"}, result, exp);
  endtask

  task automatic idleAfter(input string tag, input logic [W-1:0] exp);
    @(posedge clk);
    #1;
    checkOutput({tag, " done drop"}, {31'b0, done}, 32'd0);
    checkOutput({tag, " result keep"}, result, exp);
  endtask

  initial begin
    int done_seen;

    #1 rst = 1'b1;
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp("DIV 7/2", OP_DIV, 32'd7, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0);
    idleAfter("DIV 7/2", 32'd3);
    runOp("REM 7/2", OP_REM, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0);
    idleAfter("REM 7/2", 32'd1);

    runOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    idleAfter("DIV -7/2", 32'hFFFF_FFFD);
    runOp("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    idleAfter("REM -7/2", 32'hFFFF_FFFF);
    runOp("REM 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idleAfter("REM 7/-2", 32'd1);
    runOp("DIV -8/3", OP_DIV, 32'hFFFF_FFF8, 32'd3, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);
    idleAfter("DIV -8/3", 32'hFFFF_FFFE);

    runOp("DIVU", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    idleAfter("DIVU", 32'h0FFF_FFFF);
    runOp("REMU", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, 1'b0);
    idleAfter("REMU", 32'hF);
    runOp("DIV -1/16", OP_DIV, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'hF, 1'b0, 1'b0);
    idleAfter("DIV -1/16", 32'd0);
    runOp("DIVU big", OP_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
    runOp("REMU big", OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0);
    idleAfter("REMU big", 32'hFFFF_FFFE);

    runOp("DIV /0", OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    idleAfter("DIV /0", 32'hFFFF_FFFF);
    runOp("REM /0", OP_REM, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idleAfter("REM /0", 32'h1234_5678);
    runOp("DIVU /0", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
    idleAfter("DIVU /0", 32'hFFFF_FFFF);
    runOp("REMU /0", OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idleAfter("REMU /0", 32'h1234_5678);
    runOp("REM neg/0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'h1234_5678, 1'b0, 1'b0);
    idleAfter("REM neg/0", 32'hFFFF_FFF9);

    runOp("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 1'b0, 1'b0);
    idleAfter("DIV ovf", 32'h8000_0000);
    runOp("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    idleAfter("REM ovf", 32'd0);

    runOp("glitch DIV 100/7", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd0, 1'b0, 1'b1);
    idleAfter("glitch DIV 100/7", 32'd14);

    runOp("b2b first", OP_DIVU, 32'd1000, 32'd10, 32'd100, 32'd14, 1'b0, 1'b0);
    runOp("b2b second", OP_REMU, 32'd1000, 32'd7, 32'd6, 32'd100, 1'b1, 1'b0);
    idleAfter("b2b second", 32'd6);

    @(negedge clk);
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid-reset busy", {31'b0, busy}, 32'd0);
    checkOutput("mid-reset done", {31'b0, done}, 32'd0);
    checkOutput("mid-reset result", result, 32'd0);
    #3 rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("no done after reset", done_seen, 32'd0);
    checkOutput("idle after reset", {31'b0, busy}, 32'd0);

    runOp("post-reset DIVU", OP_DIVU, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    idleAfter("post-reset DIVU", 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/int_divider.md
# int_divider

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU operations, the sequential counterpart to the single-cycle integer ALU in the execute stage. It accepts one operation per start pulse and computes the quotient or remainder over WIDTH clock cycles. It returns the result with a one-cycle done pulse. The execute stage stalls on busy and captures result when done is high.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (at least 4)

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  reset, asynchronous and active-high
- start  input  1  request; sampled only when ready to accept (state IDLE or FIN)
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  input  WIDTH  dividend; captured at the accepted start edge
- b  input  WIDTH  divisor; captured at the accepted start edge
- busy  output  1  high while iterating (state CALC)
- done  output  1  one-cycle pulse; result valid (state FIN)
- result  output  WIDTH  registered quotient or remainder; held until the next completion

## Operation
- States: IDLE, CALC, FIN. busy = (state==CALC). done = (state==FIN).
- IDLE/FIN with start=1:
  - Latch op, signedness (op[0]==0), and |a|, |b| (absolute values for signed ops, raw values for unsigned).
  - Latch the quotient sign: signed && a[MSB]!=b[MSB] && b!=0.
  - Latch the remainder sign: signed && a[MSB].
  - Clear the partial remainder; load the step counter with WIDTH-1; go to CALC.
- IDLE/FIN with start=0: go to (or stay in) IDLE.
- CALC, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem with a WIDTH+1-bit subtraction.
  - If the difference is non-negative, rem = diff and quo LSB = 1; otherwise quo LSB = 0.
  - Decrement the counter. At counter==0, go to FIN.
- Entering FIN, result is loaded from the final step with sign correction: two's-complement negate the quotient and/or remainder per the latched signs. op[1] selects remainder (1) or quotient (0).
- Special cases, which use the same fixed latency and no early exit:
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = a (original, unmodified dividend).
  - Signed overflow (a = most-negative, b = -1): DIV result = most-negative; REM result = 0.
- Inputs a, b and op may change freely after the accepted start edge without effect.
- start while in CALC is ignored; there is no queueing.

## Timing
- Reset, asynchronous: state=IDLE, busy=0, done=0, result=0, and internal registers cleared. Takes effect immediately, with no clock required.
- Reset mid-operation aborts the operation. No done is produced, and result reads 0 after reset.
- Latency, with start accepted at rising edge N:
  - busy is high for the cycles following edges N through N+WIDTH-1 (WIDTH cycles).
  - done is high for exactly the one cycle following edge N+WIDTH.
  - result is valid from edge N+WIDTH onward.
- Back-to-back: a start during the FIN cycle is accepted at edge N+WIDTH+1. Throughput is one operation per WIDTH+1 cycles, and done never stays high for two consecutive cycles.
- result does not change during CALC; it keeps the previous operation's value until the new FIN.
- If start arrives in the same cycle that rst deasserts, the start is sampled normally at the next edge.

## Test plan
- DIV: a=7, b=2, start pulse at edge N.
  - Response: busy for 32 cycles, done only in the cycle after edge N+32, result=3.
  - Repeat with REM: result=1.
- Signed: a=-7 (0xFFFFFFF9), b=2.
  - DIV → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1).
  - a=7, b=-2: REM → 1.
- Unsigned: a=0xFFFFFFFF, b=0x10.
  - DIVU → 0x0FFFFFFF; REMU → 0xF.
  - Same operands with DIV → 0 (i.e. -1/16 truncates to 0).
- Edge cases:
  - b=0, a=0x12345678: DIV and DIVU → 0xFFFFFFFF; REM and REMU → 0x12345678.
  - a=0x80000000, b=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- Handshake:
  - start re-asserted with new operands mid-CALC → ignored; the original result is unaffected.
  - start held high in the FIN cycle → the second operation completes with done exactly 33 cycles after the first done.
- Reset: rst pulsed (asynchronously, between edges) at iteration 10 → busy, done and result drop to 0 immediately; no done follows; a subsequent op completes normally.
